// File: rtl/piso_shift_tx_if.sv
// Word-load handshake and framed serial output bundle for piso_shift_tx.
// master = upstream producer / serial observer; slave = the transmitter.
interface piso_shift_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output load_valid,
    output parallel_in,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  done
  );

  modport slave (
    input  load_valid,
    input  parallel_in,
    output load_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output done
  );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with framing strobes and gapless back-to-back loads.
// Define PISO_PARITY_EN to append an even-parity bit (state PAR) after the data bits.
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  piso_shift_tx_if.slave  tx
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             so_q, so_nxt;
  logic             sv_q, sv_nxt;
  logic             fs_q, fs_nxt;
  logic             dn_q, dn_nxt;
  logic             last_bit;
  logic             accept;
  logic             data_end;
`ifdef PISO_PARITY_EN
  logic             par_q, par_nxt;
`endif

  // The shift register is kept pre-advanced so the next bit to send is always at its head.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign data_end = (bit_cnt == CW'(WIDTH));

`ifdef PISO_PARITY_EN
  assign last_bit = (state == PAR);
`else
  assign last_bit = (state == SHIFT) && data_end;
`endif

  assign tx.load_ready = (state == IDLE) || last_bit;
  assign accept        = tx.load_valid && tx.load_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
      SHIFT: if (data_end) state_nxt = PAR;
      PAR:   state_nxt = accept ? SHIFT : IDLE;
`else
      SHIFT: if (data_end && !accept) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Accept can only occur in IDLE or on the last frame bit, so it never collides with mid-frame shifting.
  always_comb begin
    so_nxt      = 1'b0;
    sv_nxt      = 1'b0;
    fs_nxt      = 1'b0;
    dn_nxt      = 1'b0;
    sreg_nxt    = sreg;
    bit_cnt_nxt = '0;
`ifdef PISO_PARITY_EN
    par_nxt     = par_q;
`endif
    if (accept) begin
      so_nxt      = head(tx.parallel_in);
      sv_nxt      = 1'b1;
      fs_nxt      = 1'b1;
      sreg_nxt    = advance(tx.parallel_in);
      bit_cnt_nxt = CW'(1);
`ifdef PISO_PARITY_EN
      par_nxt     = ^tx.parallel_in;
`endif
    end else if (state == SHIFT) begin
      if (!data_end) begin
        so_nxt      = head(sreg);
        sv_nxt      = 1'b1;
        sreg_nxt    = advance(sreg);
        bit_cnt_nxt = bit_cnt + CW'(1);
`ifdef PISO_PARITY_EN
        dn_nxt      = 1'b0;
`else
        dn_nxt      = (bit_cnt == CW'(WIDTH - 1));
`endif
      end
`ifdef PISO_PARITY_EN
      else begin
        so_nxt      = par_q;
        sv_nxt      = 1'b1;
        dn_nxt      = 1'b1;
        bit_cnt_nxt = bit_cnt;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
      dn_q    <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sreg    <= sreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      so_q    <= so_nxt;
      sv_q    <= sv_nxt;
      fs_q    <= fs_nxt;
      dn_q    <= dn_nxt;
`ifdef PISO_PARITY_EN
      par_q   <= par_nxt;
`endif
    end
  end

  assign tx.serial_out   = so_q;
  assign tx.serial_valid = sv_q;
  assign tx.frame_start  = fs_q;
  assign tx.done         = dn_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: table-driven frames through a scoreboard,
// plus hand sequences for reset abort, LSB-first and WIDTH=8 instances.
module tb_piso_shift_tx;

`ifdef PISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  always #5 clk = ~clk;

  piso_shift_tx_if #(.WIDTH(4)) bus  ();
  piso_shift_tx_if #(.WIDTH(4)) bus2 ();
  piso_shift_tx_if #(.WIDTH(8)) bus8 ();

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut   (.clk(clk), .rst(rst), .tx(bus.slave));
  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .tx(bus2.slave));
  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_8 (.clk(clk), .rst(rst), .tx(bus8.slave));

  typedef struct {
    logic b;
    logic fs;
    logic dn;
  } exp_t;

  typedef struct {
    logic [3:0] word;
    logic [3:0] exp_seq;   // expected serial order, bit 3 goes out first
    int         gap;
    bit         jitter;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0] seq, input logic [3:0] word);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.b  = seq[3-i];
      e.fs = (i == 0);
      e.dn = (PB == 0) && (i == 3);
      sb_q.push_back(e);
    end
    if (PB != 0) begin
      e.b  = ^word;
      e.fs = 1'b0;
      e.dn = 1'b1;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.serial_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_serial_valid", 32'(bus.serial_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("serial_out",  32'(bus.serial_out),  32'(e.b));
          chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
          chk("done",        32'(bus.done),        32'(e.dn));
        end
      end else begin
        chk("idle_outputs", {29'd0, bus.serial_out, bus.frame_start, bus.done}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] seq_l;
    logic [8:0] seq_8;
    bit         accepted;
    int         wait_c;

    tbl[0] = '{word: 4'b1010, exp_seq: 4'b1010, gap: 2, jitter: 1'b0};
    tbl[1] = '{word: 4'b1100, exp_seq: 4'b1100, gap: 2, jitter: 1'b0};
    tbl[2] = '{word: 4'b0011, exp_seq: 4'b0011, gap: 0, jitter: 1'b0};
    tbl[3] = '{word: 4'b0110, exp_seq: 4'b0110, gap: 3, jitter: 1'b0};
    tbl[4] = '{word: 4'b1001, exp_seq: 4'b1001, gap: 0, jitter: 1'b1};
    tbl[5] = '{word: 4'b0000, exp_seq: 4'b0000, gap: 1, jitter: 1'b0};
    tbl[6] = '{word: 4'b1111, exp_seq: 4'b1111, gap: 0, jitter: 1'b0};
    tbl[7] = '{word: 4'b0101, exp_seq: 4'b0101, gap: 0, jitter: 1'b1};
    tbl[8] = '{word: 4'b1000, exp_seq: 4'b1000, gap: 5, jitter: 1'b0};

    rst = 1'b1;
    bus.load_valid  = 1'b0; bus.parallel_in  = '0;
    bus2.load_valid = 1'b0; bus2.parallel_in = '0;
    bus8.load_valid = 1'b0; bus8.parallel_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("reset_outputs", {28'd0, bus.serial_out, bus.serial_valid, bus.frame_start, bus.done}, 32'd0);
    chk("reset_load_ready", 32'(bus.load_ready), 32'd1);
    chk("reset_outputs_w8", {28'd0, bus8.serial_out, bus8.serial_valid, bus8.frame_start, bus8.done}, 32'd0);

    // LSB-first 4'b0001 and MSB-first 8'hA5, launched together from IDLE.
    seq_l = 5'b1_0001;
    seq_8 = 9'b0_1010_0101;
    @(posedge clk); #1;
    bus2.load_valid = 1'b1; bus2.parallel_in = 4'b0001;
    bus8.load_valid = 1'b1; bus8.parallel_in = 8'hA5;
    @(posedge clk); #1;
    bus2.load_valid = 1'b0; bus2.parallel_in = 4'b1110;
    bus8.load_valid = 1'b0; bus8.parallel_in = 8'h3C;
    for (int i = 0; i < 8 + PB; i++) begin
      @(negedge clk);
      if (i < 4 + PB) begin
        chk("lsb_serial_out", 32'(bus2.serial_out), 32'(seq_l[i]));
        chk("lsb_done", 32'(bus2.done), 32'(i == 3 + PB));
      end else begin
        chk("lsb_idle_valid", 32'(bus2.serial_valid), 32'd0);
      end
      chk("w8_serial_out", 32'(bus8.serial_out), 32'(seq_8[i]));
      chk("w8_frame_start", 32'(bus8.frame_start), 32'(i == 0));
      chk("w8_done", 32'(bus8.done), 32'(i == 7 + PB));
    end
    @(negedge clk);
    chk("w8_idle_valid", 32'(bus8.serial_valid), 32'd0);

    // Table-driven frames through the scoreboard.
    @(posedge clk); #1;
    mon_en = 1'b1;
    foreach (tbl[k]) begin
      bus.load_valid = 1'b0;
      repeat (tbl[k].gap) begin
        @(posedge clk); #1;
      end
      bus.load_valid  = 1'b1;
      bus.parallel_in = tbl[k].jitter ? 4'($urandom) : tbl[k].word;
      accepted = 1'b0;
      for (int c = 0; c < 40 && !accepted; c++) begin
        @(negedge clk);
        if (bus.load_ready) begin
          bus.parallel_in = tbl[k].word;
          push_frame(tbl[k].exp_seq, tbl[k].word);
          accepted = 1'b1;
        end else if (tbl[k].jitter) begin
          bus.parallel_in = 4'($urandom);
        end
        @(posedge clk); #1;
      end
      if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
      bus.load_valid  = 1'b0;
      bus.parallel_in = 4'($urandom);
    end
    wait_c = 0;
    while (sb_q.size() != 0 && wait_c < 40) begin
      @(negedge clk);
      wait_c++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    mon_en = 1'b0;

    // Reset mid-frame: abort with no done pulse and no resend.
    bus.load_valid = 1'b1; bus.parallel_in = 4'b1111;
    @(negedge clk);
    chk("abort_ready_before", 32'(bus.load_ready), 32'd1);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    @(negedge clk);
    chk("abort_first_bit", {30'd0, bus.serial_out, bus.frame_start}, 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {28'd0, bus.serial_out, bus.serial_valid, bus.frame_start, bus.done}, 32'd0);
    chk("abort_load_ready", 32'(bus.load_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_resend", {30'd0, bus.serial_valid, bus.done}, 32'd0);
    end

    // Reset wins over a simultaneous load in IDLE.
    @(posedge clk); #1;
    rst = 1'b1; bus.load_valid = 1'b1; bus.parallel_in = 4'b1011;
    @(posedge clk); #1;
    rst = 1'b0; bus.load_valid = 1'b0;
    @(negedge clk);
    chk("rst_priority_valid", 32'(bus.serial_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
